// File: rtl/regfile_sb.sv
// regfile_sb: three-port register file with a pending-write scoreboard.
// Two combinational read ports feed the ALU operands, one synchronous write
// port retires results. Registers with an outstanding multi-cycle producer
// are marked pending. Stall is raised when an operand or a new destination
// is still awaiting its write.
module regfile_sb #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [AW-1:0]        A1,
  input  logic [AW-1:0]        A2,
  output logic [WIDTH-1:0]     RD1,
  output logic [WIDTH-1:0]     RD2,
  input  logic                 WE3,
  input  logic [AW-1:0]        A3,
  input  logic [WIDTH-1:0]     WD3,
  input  logic                 Issue,
  input  logic [AW-1:0]        IssueDst,
  output logic                 Stall,
  output logic [(2**AW)-1:0]   Pending
);

  localparam int NREG = 2**AW;

  logic [WIDTH-1:0] regs_q [NREG];
  logic [NREG-1:0]  pending_q;
  logic [NREG-1:0]  pending_d;

  logic wr_en;
  logic hit_a1;
  logic hit_a2;
  logic hit_dst;
  logic set_en;

  // A write to register 0 never lands anywhere.
  assign wr_en = WE3 && (A3 != '0);

  // Combinational reads: register 0 reads as zero, a same-cycle write bypasses the array.
  always_comb begin
    RD1 = '0;
    if (A1 != '0) begin
      if (WE3 && (A3 == A1)) RD1 = WD3;
      else                   RD1 = regs_q[A1];
    end
    RD2 = '0;
    if (A2 != '0) begin
      if (WE3 && (A3 == A2)) RD2 = WD3;
      else                   RD2 = regs_q[A2];
    end
  end

  // Hazard detection: a pending register is fine if its write is arriving this cycle.
  always_comb begin
    hit_a1  = (A1 != '0) && pending_q[A1] && !(WE3 && (A3 == A1));
    hit_a2  = (A2 != '0) && pending_q[A2] && !(WE3 && (A3 == A2));
    hit_dst = Issue && (IssueDst != '0) && pending_q[IssueDst] &&
              !(WE3 && (A3 == IssueDst));
    Stall   = hit_a1 || hit_a2 || hit_dst;
  end

  // An issue only claims its destination when nothing is stalling it.
  assign set_en = Issue && !Stall && (IssueDst != '0);

  // Scoreboard next state: clear on retire first, then set so a new producer wins.
  always_comb begin
    pending_d = pending_q;
    if (wr_en)  pending_d[A3]       = 1'b0;
    if (set_en) pending_d[IssueDst] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Scoreboard state, cleared by reset ahead of any issue or retire.
  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  // Register array; reset clears every entry and overrides a concurrent write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[A3] <= WD3;
    end
  end

  assign Pending = pending_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vectors, a register/scoreboard model that is
// compared on every falling edge, and hand-computed literal checks.
module tb_regfile_sb;

  localparam int WIDTH = 32;
  localparam int AW    = 5;
  localparam int NREG  = 2**AW;

  logic             clk = 1'b0;
  logic             reset;
  logic [AW-1:0]    A1, A2, A3, IssueDst;
  logic [WIDTH-1:0] RD1, RD2, WD3;
  logic             WE3, Issue, Stall;
  logic [NREG-1:0]  Pending;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] m_reg  [NREG];
  bit               m_pend [NREG];
  bit               m_valid = 1'b0;

  regfile_sb #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .WE3(WE3), .A3(A3), .WD3(WD3),
    .Issue(Issue), .IssueDst(IssueDst),
    .Stall(Stall), .Pending(Pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: what a read returns given the architectural state and this cycle's write.
  function automatic logic [31:0] m_read(input logic [AW-1:0] a);
    if (a == 0) return 32'h0;
    if (WE3 && A3 == a) return WD3;
    return m_reg[a];
  endfunction

  // Model: a register blocks if it awaits a write that is not arriving now.
  function automatic bit m_blocked(input logic [AW-1:0] a);
    return (a != 0) && m_pend[a] && !(WE3 && A3 == a);
  endfunction

  function automatic bit m_stall();
    return m_blocked(A1) || m_blocked(A2) || (Issue && m_blocked(IssueDst));
  endfunction

  function automatic logic [31:0] m_pend_vec();
    logic [31:0] v = '0;
    for (int i = 1; i < NREG; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // Model update on each rising edge.
  always @(posedge clk) begin
    bit st;
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        m_reg[i]  = '0;
        m_pend[i] = 1'b0;
      end
      m_valid = 1'b1;
    end else if (m_valid) begin
      st = m_stall();
      if (WE3 && A3 != 0) begin
        m_reg[A3]  = WD3;
        m_pend[A3] = 1'b0;
      end
      if (Issue && !st && IssueDst != 0) m_pend[IssueDst] = 1'b1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_rd1",     RD1,           m_read(A1));
      check("model_rd2",     RD2,           m_read(A2));
      check("model_stall",   {31'h0, Stall}, {31'h0, m_stall()});
      check("model_pending", Pending,       m_pend_vec());
    end
  end

  task automatic idle();
    WE3 = 1'b0; A3 = '0; WD3 = '0; Issue = 1'b0; IssueDst = '0;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; A1 = '0; A2 = '0; idle();
    next();
    reset = 1'b0; A1 = 5'd5; A2 = 5'd31;
    settle();
    check("rst_rd1", RD1, 32'h0);
    check("rst_rd2", RD2, 32'h0);
    check("rst_stall", {31'h0, Stall}, 32'h0);
    check("rst_pending", Pending, 32'h0);

    // write reg4, bypass on RD2 in the write cycle
    next();
    WE3 = 1'b1; A3 = 5'd4; WD3 = 32'h0000_0004; A1 = 5'd0; A2 = 5'd4;
    settle();
    check("bypass_rd2", RD2, 32'h4);
    next();
    idle(); A1 = 5'd4; A2 = 5'd0;
    settle();
    check("read_rd1", RD1, 32'h4);

    // register 0 discards writes and issues
    next();
    WE3 = 1'b1; A3 = 5'd0; WD3 = 32'hDEAD_BEEF;
    next();
    idle(); A1 = 5'd0; Issue = 1'b1; IssueDst = 5'd0;
    settle();
    check("r0_rd1", RD1, 32'h0);
    check("r0_issue_stall", {31'h0, Stall}, 32'h0);
    next();
    idle();
    settle();
    check("r0_pending", Pending, 32'h0);

    // operand stall on reg3, resolved by the arriving write
    next();
    Issue = 1'b1; IssueDst = 5'd3;
    next();
    idle(); A1 = 5'd3;
    settle();
    check("p3_set", Pending, 32'h0000_0008);
    check("op_stall", {31'h0, Stall}, 32'h1);
    next();
    WE3 = 1'b1; A3 = 5'd3; WD3 = 32'd7;
    settle();
    check("resolve_stall", {31'h0, Stall}, 32'h0);
    check("resolve_rd1", RD1, 32'd7);
    next();
    idle();
    settle();
    check("p3_clear", Pending, 32'h0);
    check("after_rd1", RD1, 32'd7);

    // WAW on reg6, then set-wins
    next();
    A1 = 5'd0; Issue = 1'b1; IssueDst = 5'd6;
    next();
    Issue = 1'b1; IssueDst = 5'd6;
    settle();
    check("waw_stall", {31'h0, Stall}, 32'h1);
    next();
    idle();
    settle();
    check("waw_pending", Pending, 32'h0000_0040);
    next();
    Issue = 1'b1; IssueDst = 5'd6; WE3 = 1'b1; A3 = 5'd6; WD3 = 32'h1234_5678;
    settle();
    check("setwin_stall", {31'h0, Stall}, 32'h0);
    next();
    idle();
    settle();
    check("setwin_pending", Pending, 32'h0000_0040);

    // multiple pending registers; A2 hazard; legal write to non-pending reg
    next();
    Issue = 1'b1; IssueDst = 5'd9;
    next();
    Issue = 1'b1; IssueDst = 5'd3;
    next();
    idle(); A2 = 5'd9;
    settle();
    check("multi_pending", Pending, 32'h0000_0248);
    check("a2_stall", {31'h0, Stall}, 32'h1);
    next();
    A2 = 5'd0; A1 = 5'd6; WE3 = 1'b1; A3 = 5'd6; WD3 = 32'hCAFE_F00D;
    settle();
    check("a1_resolve", {31'h0, Stall}, 32'h0);
    next();
    idle(); A1 = 5'd0; WE3 = 1'b1; A3 = 5'd12; WD3 = 32'hFFFF_FFFF;
    next();
    idle(); A1 = 5'd12; A2 = 5'd6;
    settle();
    check("np_write_rd1", RD1, 32'hFFFF_FFFF);
    check("np_write_pend", Pending, 32'h0000_0208);
    check("r6_rd2", RD2, 32'hCAFE_F00D);

    // a few more model-checked writes and reads
    for (int k = 0; k < 8; k++) begin
      next();
      idle();
      WE3 = 1'b1; A3 = 5'(k * 3 + 10); WD3 = 32'h1111_0000 + 32'(k);
      A1 = 5'(k * 3 + 10); A2 = 5'(k * 3 + 7);
    end
    next();
    idle(); A1 = 5'd13; A2 = 5'd31;
    settle();
    check("loop_rd1", RD1, 32'h1111_0001);
    check("loop_rd2", RD2, 32'h1111_0007);

    // reset mid-operation beats the concurrent write
    next();
    A1 = 5'd0; A2 = 5'd0;
    reset = 1'b1; WE3 = 1'b1; A3 = 5'd3; WD3 = 32'd5;
    next();
    reset = 1'b0; idle(); A1 = 5'd3; A2 = 5'd4;
    settle();
    check("rst_mid_pending", Pending, 32'h0);
    check("rst_mid_r3", RD1, 32'h0);
    check("rst_mid_r4", RD2, 32'h0);
    next();
    next();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
